// File: rtl/title_fade_overlay_if.sv
// Pixel/ROM/fade bundle between the video source and the title overlay.
//   master : video source side (drives scan position, status, vsync, ROM data)
//   slave  : overlay side (drives ROM address, title pixel and fade state)
interface title_fade_overlay_if #(
    parameter int ADDR_W = 20
);
    logic              vsync_pulse;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [3:0]        status;
    logic [ADDR_W-1:0] rom_address;
    logic [1:0]        rom_data;
    logic              is_title;
    logic [23:0]       title_color;
    logic [4:0]        fade_level;
    logic              fade_busy;

    modport master (
        output vsync_pulse, DrawX, DrawY, status, rom_data,
        input  rom_address, is_title, title_color, fade_level, fade_busy
    );

    modport slave (
        input  vsync_pulse, DrawX, DrawY, status, rom_data,
        output rom_address, is_title, title_color, fade_level, fade_busy
    );
endinterface

// File: rtl/title_fade_overlay.sv
// Title-card overlay: tests the scan position against a sprite window,
// fetches the palette index from an external synchronous ROM and drives a
// faded colour. A four-state FSM fades the card in/out over vsync pulses.
// Ports:
//   Clk   : pixel clock
//   Reset : asynchronous, active-high
//   bus   : title_fade_overlay_if.slave (scan position, status, vsync,
//           ROM address/data, is_title, title_color, fade_level, fade_busy)
// Latency DrawX/DrawY -> is_title/title_color is 2 cycles, one pixel/cycle.
module title_fade_overlay #(
    parameter int          X0          = 224,
    parameter int          Y0          = 224,
    parameter int          W           = 192,
    parameter int          H           = 32,
    parameter int          ADDR_W      = 20,
    parameter logic [3:0]  STATUS_ID   = 4'd1,
    parameter int          FADE_FRAMES = 4,
    parameter logic [23:0] COL1        = 24'h818181,
    parameter logic [23:0] COL2        = 24'hFF0000,
    parameter logic [23:0] COL3        = 24'hFFFFFF
) (
    input logic                Clk,
    input logic                Reset,
    title_fade_overlay_if.slave bus
);
    localparam int CNT_W = (FADE_FRAMES < 2) ? 1 : $clog2(FADE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       level_reg, level_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             title_on;
    logic             busy;
    logic             step_due;

    assign title_on = (bus.status == STATUS_ID);
    assign busy     = (state_reg == FADE_IN) || (state_reg == FADE_OUT);
    // The pulse that would bring the count to FADE_FRAMES.
    assign step_due = busy && bus.vsync_pulse &&
                      (count_reg == CNT_W'(FADE_FRAMES - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            level_reg <= 5'd0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        count_next = count_reg;
        // A status-driven transition takes priority and suppresses any step
        // that would otherwise happen on the same vsync pulse.
        case (state_reg)
            IDLE: begin
                if (title_on) state_next = FADE_IN;
            end
            FADE_IN: begin
                if (!title_on) begin
                    state_next = FADE_OUT;
                end else if (level_reg == 5'd16) begin
                    state_next = SHOW;
                end else if (step_due) begin
                    level_next = level_reg + 5'd1;
                    if (level_reg == 5'd15) state_next = SHOW;
                end
            end
            SHOW: begin
                if (!title_on) state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (title_on) begin
                    state_next = FADE_IN;
                end else if (level_reg == 5'd0) begin
                    state_next = IDLE;
                end else if (step_due) begin
                    level_next = level_reg - 5'd1;
                    if (level_reg == 5'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) begin
            count_next = '0;
        end else if (busy && bus.vsync_pulse) begin
            count_next = step_due ? '0 : count_reg + CNT_W'(1);
        end
    end

    assign bus.fade_level = level_reg;
    assign bus.fade_busy  = busy;

    // ------------------------------------------------ stage 1: window hit
    logic [31:0]       x_ext, y_ext, addr_full;
    logic              hit;
    logic              hit1_reg;

    assign x_ext = {22'd0, bus.DrawX};
    assign y_ext = {22'd0, bus.DrawY};
    assign hit   = (x_ext >= 32'(X0)) && (x_ext < 32'(X0 + W)) &&
                   (y_ext >= 32'(Y0)) && (y_ext < 32'(Y0 + H));
    assign addr_full = (y_ext - 32'(Y0)) * 32'(W) + (x_ext - 32'(X0));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit1_reg        <= 1'b0;
            bus.rom_address <= '0;
        end else begin
            hit1_reg        <= hit;
            bus.rom_address <= hit ? ADDR_W'(addr_full) : '0;
        end
    end

    // ------------------------------------------- stage 2: palette + fade
    logic [23:0] base_color;
    logic [23:0] scaled_color;
    logic        opaque;

    always_comb begin
        base_color = 24'd0;
        case (bus.rom_data)
            2'd1:    base_color = COL1;
            2'd2:    base_color = COL2;
            2'd3:    base_color = COL3;
            default: base_color = 24'd0;
        endcase
    end

    // Per channel (c * level) >> 4 with a 13-bit product; level 16 is exact.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [12:0] prod;
        assign prod = {5'd0, base_color[gi*8 +: 8]} * {8'd0, level_reg};
        assign scaled_color[gi*8 +: 8] = 8'(prod >> 4);
    end

    assign opaque = hit1_reg && (bus.rom_data != 2'd0) && (level_reg != 5'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.is_title    <= 1'b0;
            bus.title_color <= 24'd0;
        end else begin
            bus.is_title    <= opaque;
            bus.title_color <= opaque ? scaled_color : 24'd0;
        end
    end
endmodule

// File: tb/tb_title_fade_overlay.sv
// Directed bench for title_fade_overlay: stimulus pushes expected ROM
// addresses and pixels into queues, a negedge monitor pops and compares.
module tb_title_fade_overlay;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    title_fade_overlay_if #(.ADDR_W(20)) bus ();

    title_fade_overlay dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Sprite ROM model: data presented in the cycle after the address edge.
    logic [1:0] rom_mem [0:8191];
    assign bus.rom_data = rom_mem[bus.rom_address[12:0]];

    int checks   = 0;
    int failures = 0;

    logic [19:0] addr_q [$];
    logic [24:0] pix_q  [$];
    logic        issue = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge Clk) begin
        v1 <= issue;
        v2 <= v1;
    end

    // Monitor: v1 marks a cycle where rom_address belongs to an issued
    // pixel, v2 the cycle its is_title/title_color appear.
    always @(negedge Clk) begin
        logic [19:0] ea;
        logic [24:0] ep;
        if (v1) begin
            if (addr_q.size() == 0) chk("addr_queue_underflow", 32'd1, 32'd0);
            else begin
                ea = addr_q.pop_front();
                $display("addr  act=%0d exp=%0d", bus.rom_address, ea);
                chk("rom_address", 32'(bus.rom_address), 32'(ea));
            end
        end
        if (v2) begin
            if (pix_q.size() == 0) chk("pix_queue_underflow", 32'd1, 32'd0);
            else begin
                ep = pix_q.pop_front();
                $display("pixel act=%0b/%h exp=%0b/%h", bus.is_title, bus.title_color, ep[24], ep[23:0]);
                chk("is_title", 32'(bus.is_title), 32'(ep[24]));
                chk("title_color", 32'(bus.title_color), 32'(ep[23:0]));
            end
        end
    end

    task automatic pixel(input int x, input int y, input logic [19:0] ea,
                         input logic ei, input logic [23:0] ec);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        issue = 1'b1;
        addr_q.push_back(ea);
        pix_q.push_back({ei, ec});
        @(negedge Clk);
    endtask

    task automatic drain();
        issue = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic pulse();
        bus.vsync_pulse = 1'b1;
        @(negedge Clk);
        bus.vsync_pulse = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse();
    endtask

    task automatic chk_fade(input string nm, input int lvl, input logic bsy);
        $display("fade  %s level=%0d busy=%0b exp=%0d/%0b", nm, bus.fade_level, bus.fade_busy, lvl, bsy);
        chk({nm, "_level"}, 32'(bus.fade_level), 32'(lvl));
        chk({nm, "_busy"}, 32'(bus.fade_busy), 32'(bsy));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 2'd0;
        rom_mem[0]    = 2'd1;   // (224,224); also the address used on a miss
        rom_mem[1]    = 2'd0;   // (225,224) transparent
        rom_mem[192]  = 2'd3;   // (224,225)
        rom_mem[6143] = 2'd2;   // (415,255) last window pixel

        Reset = 1'b1;
        bus.vsync_pulse = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.status = 4'd0;
        repeat (2) @(negedge Clk);
        chk("reset_rom_address", 32'(bus.rom_address), 32'd0);
        chk("reset_is_title", 32'(bus.is_title), 32'd0);
        chk("reset_title_color", 32'(bus.title_color), 32'd0);
        chk_fade("reset", 0, 1'b0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk_fade("idle", 0, 1'b0);

        // Status change and vsync in the same cycle: no step, count cleared.
        bus.status = 4'd1;
        bus.vsync_pulse = 1'b1;
        @(negedge Clk);
        bus.vsync_pulse = 1'b0;
        chk_fade("simul", 0, 1'b1);
        pulses(3);
        chk_fade("after3", 0, 1'b1);
        pulse();
        chk_fade("after4", 1, 1'b1);
        for (int p = 5; p <= 64; p++) begin
            pulse();
            if (p % 4 == 0) chk_fade("fade_in", p / 4, (p != 64));
        end

        // SHOW at level 16: window hits, misses and boundaries, back-to-back.
        pixel(224, 225, 20'd192, 1'b1, 24'hFFFFFF);
        pixel(416, 225, 20'd0, 1'b0, 24'h000000);
        pixel(224, 224, 20'd0, 1'b1, 24'h818181);
        pixel(415, 255, 20'd6143, 1'b1, 24'hFF0000);
        pixel(223, 230, 20'd0, 1'b0, 24'h000000);
        pixel(300, 256, 20'd0, 1'b0, 24'h000000);
        pixel(300, 223, 20'd0, 1'b0, 24'h000000);
        pixel(225, 224, 20'd1, 1'b0, 24'h000000);
        drain();

        // Fade out 20 pulses -> level 11.
        bus.status = 4'd2;
        @(negedge Clk);
        chk_fade("fade_out_start", 16, 1'b1);
        pulses(20);
        chk_fade("fade_out_20", 11, 1'b1);
        pixel(415, 255, 20'd6143, 1'b1, 24'hAF0000);
        pixel(224, 225, 20'd192, 1'b1, 24'hAFAFAF);
        pixel(224, 224, 20'd0, 1'b1, 24'h585858);
        drain();

        // Reverse: fade in continues from 11.
        bus.status = 4'd1;
        @(negedge Clk);
        chk_fade("refade_start", 11, 1'b1);
        pulses(20);
        chk_fade("refade_20", 16, 1'b0);

        // Fade out to level 8.
        bus.status = 4'd2;
        @(negedge Clk);
        pulses(32);
        chk_fade("fade_out_32", 8, 1'b1);
        pixel(415, 255, 20'd6143, 1'b1, 24'h7F0000);
        pixel(224, 225, 20'd192, 1'b1, 24'h7F7F7F);
        pixel(224, 224, 20'd0, 1'b1, 24'h404040);
        pixel(225, 224, 20'd1, 1'b0, 24'h000000);
        drain();

        // Down to 0 -> IDLE; nothing drawn.
        pulses(32);
        chk_fade("fade_out_done", 0, 1'b0);
        pixel(224, 225, 20'd192, 1'b0, 24'h000000);
        drain();

        // Back to SHOW, then asynchronous reset mid-line.
        bus.status = 4'd1;
        @(negedge Clk);
        pulses(64);
        chk_fade("show_again", 16, 1'b0);
        bus.DrawX = 10'd224;
        bus.DrawY = 10'd225;
        repeat (3) @(negedge Clk);
        chk("pre_reset_is_title", 32'(bus.is_title), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rom_address", 32'(bus.rom_address), 32'd0);
        chk("async_is_title", 32'(bus.is_title), 32'd0);
        chk("async_title_color", 32'(bus.title_color), 32'd0);
        chk_fade("async", 0, 1'b0);
        bus.status = 4'd0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk_fade("post_reset_idle", 0, 1'b0);
        chk("post_reset_is_title", 32'(bus.is_title), 32'd0);
        bus.status = 4'd1;
        @(negedge Clk);
        chk_fade("post_reset_fade_in", 0, 1'b1);

        chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        chk("pix_queue_empty", 32'(pix_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
